proc_issuer: RTL and testbench

- Issuer side of the SIMD processor instruction interface.
- Buffers vector commands from the scheduler in a small FIFO, then runs one command at a time on its attached proc:
  - starts the proc with a one-cycle enable;
  - sends the four setup words LD src0, LD src1, INFO, STORE dst using single-cycle valid pulses, checking the ack after each;
  - waits for the proc's finish, acknowledges it, and reports completion upstream.
- Sits between the command scheduler and one proc instance.

---
 rtl/proc_issuer_pkg.sv | 53 +++++
 rtl/proc_issuer_if.sv | 20 ++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/proc_issuer.sv | 224 ++++++++++++++++++++++
 tb/tb_proc_issuer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_issuer_pkg.sv
// Shared types for the proc issuer: upstream command record, instruction word,
// opcode / op encodings and the INFO payload layout with its packing helper.
package proc_issuer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ID_W   = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    INSTR_NOP   = 2'd0,
    INSTR_LD    = 2'd1,
    INSTR_INFO  = 2'd2,
    INSTR_STORE = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    addr_t            src0;
    addr_t            src1;
    addr_t            dst;
  } cmd_t;

  typedef struct packed {
    opcode_e opcode;
    addr_t   payload;
  } instr_t;

  // INFO payload: {reserved, op, count}, count in the low bits.
  typedef struct packed {
    logic [ADDR_W-CNT_W-3:0] rsvd;
    logic [1:0]              op;
    logic [CNT_W-1:0]        count;
  } instr_info_t;

  function automatic addr_t pack_info(input logic [1:0] op, input logic [CNT_W-1:0] count);
    instr_info_t info;
    info       = '0;
    info.op    = op;
    info.count = count;
    return addr_t'(info);
  endfunction

endpackage

// File: rtl/proc_issuer_if.sv
// Issuer <-> proc instruction interface.
//   en     : one-cycle proc start
//   valid  : instruction word pulse, also the finish acknowledge
//   instr  : {opcode, payload}
//   ack    : proc accepted the last word
//   busy   : proc not idle
//   finish : proc in its finished state
interface proc_issuer_if;
  import proc_issuer_pkg::*;

  logic   en;
  logic   valid;
  instr_t instr;
  logic   ack;
  logic   busy;
  logic   finish;

  modport master (output en, valid, instr, input ack, busy, finish);
  modport slave  (input en, valid, instr, output ack, busy, finish);
endinterface

// File: rtl/cmd_fifo.sv
// Command FIFO with registered full/empty flags.
//   i_push/i_wdata : write, ignored when full
//   i_pop          : read, ignored when empty; o_rdata shows the head entry
//   o_full/o_empty : registered occupancy flags
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = i_push && !full_q;
  assign do_pop  = i_pop && !empty_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/proc_issuer.sv
// Issuer side of the SIMD proc instruction interface.
// Buffers scheduler commands, then per command: start pulse, four setup words
// (LD src0, LD src1, INFO, STORE dst) with ack check and retry, finish wait,
// finish acknowledge and a completion report.
//   i_cmd_valid/o_cmd_ready/i_cmd : upstream command push
//   proc                          : proc instruction interface (master side)
//   o_done_valid/id/err           : one-cycle completion report
//   o_err                         : sticky protocol error
module proc_issuer
  import proc_issuer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  cmd_t                 i_cmd,
  proc_issuer_if.master        proc,
  output logic                 o_done_valid,
  output logic [ID_W-1:0]      o_done_id,
  output logic                 o_done_err,
  output logic                 o_err
);

  localparam int unsigned RetryW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    StIdle, StEn, StWaitBusy, StPulse, StCheck, StWaitFin, StFinAck, StDone
  } state_e;

  state_e              state_q, state_d;
  cmd_t                hold_q, hold_d;
  logic [1:0]          word_q, word_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [31:0]         tmo_q, tmo_d;
  logic                derr_q, derr_d;
  logic                err_q, err_d;
  logic                fail, pop;

  logic                en_q, en_d;
  logic                valid_q, valid_d;
  instr_t              instr_q, instr_d;
  logic                done_valid_q, done_valid_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic                done_err_q, done_err_d;

  logic [$bits(cmd_t)-1:0] fifo_rdata;
  cmd_t                head;
  logic                fifo_full, fifo_empty;
  logic [31:0]         fin_limit, fin_limit_m1;

  cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (i_cmd_valid),
    .i_wdata (i_cmd),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign head = cmd_t'(fifo_rdata);

  // Finish wait scales with the element count: TIMEOUT * count / 4 cycles.
  assign fin_limit    = (32'(hold_q.count) * 32'(TIMEOUT)) >> 2;
  assign fin_limit_m1 = (fin_limit == 32'd0) ? 32'd0 : fin_limit - 32'd1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    word_d  = word_q;
    retry_d = retry_q;
    tmo_d   = tmo_q + 32'd1;
    derr_d  = derr_q;
    fail    = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (!fifo_empty && !proc.busy) begin
          pop    = 1'b1;
          hold_d = head;
          derr_d = 1'b0;
          if (head.count == '0) begin
            // Nothing to compute: report straight away, proc untouched.
            derr_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StEn;
          end
        end
      end
      StEn: begin
        tmo_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (proc.busy) begin
          word_d  = 2'd0;
          retry_d = '0;
          state_d = StPulse;
        end else if (tmo_q >= 32'(TIMEOUT) - 32'd1) begin
          fail = 1'b1;
        end
      end
      StPulse: state_d = StCheck;
      StCheck: begin
        tmo_d = '0;
        if (proc.ack) begin
          retry_d = '0;
          if (word_q == 2'd3) begin
            state_d = StWaitFin;
          end else begin
            word_d  = word_q + 2'd1;
            state_d = StPulse;
          end
        end else if (retry_q == RetryW'(MAX_RETRY)) begin
          fail = 1'b1;
        end else begin
          retry_d = retry_q + RetryW'(1);
          state_d = StPulse;
        end
      end
      StWaitFin: begin
        if (proc.finish) begin
          state_d = StFinAck;
        end else if (tmo_q >= fin_limit_m1) begin
          fail = 1'b1;
        end
      end
      StFinAck: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (fail) begin
      derr_d  = 1'b1;
      state_d = StDone;
    end
    err_d = err_q | fail;
  end

  // Outputs are decoded from the next state so they are registered and
  // line up with the state they belong to.
  always_comb begin
    en_d         = (state_d == StEn);
    valid_d      = (state_d == StPulse) || (state_d == StFinAck);
    done_valid_d = (state_d == StDone);
    done_id_d    = (state_d == StDone) ? hold_d.id : '0;
    done_err_d   = (state_d == StDone) && derr_d;
    instr_d      = '0;
    if (state_d == StPulse) begin
      unique case (word_d)
        2'd0: begin
          instr_d.opcode  = INSTR_LD;
          instr_d.payload = hold_d.src0;
        end
        2'd1: begin
          instr_d.opcode  = INSTR_LD;
          instr_d.payload = hold_d.src1;
        end
        2'd2: begin
          instr_d.opcode  = INSTR_INFO;
          instr_d.payload = pack_info(hold_d.op, hold_d.count);
        end
        2'd3: begin
          instr_d.opcode  = INSTR_STORE;
          instr_d.payload = hold_d.dst;
        end
        default: instr_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      word_q       <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      derr_q       <= 1'b0;
      err_q        <= 1'b0;
      en_q         <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      word_q       <= word_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      derr_q       <= derr_d;
      err_q        <= err_d;
      en_q         <= en_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_err_q   <= done_err_d;
    end
  end

  assign o_cmd_ready  = !fifo_full;
  assign proc.en      = en_q;
  assign proc.valid   = valid_q;
  assign proc.instr   = instr_q;
  assign o_done_valid = done_valid_q;
  assign o_done_id    = done_id_q;
  assign o_done_err   = done_err_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_proc_issuer.sv
// Bench for proc_issuer: a reactive proc model plus a table of commands with
// per-entry ack faults, followed by reset-in-flight and FIFO-fill sequences.
module tb_proc_issuer;
  import proc_issuer_pkg::*;

  localparam int FIN_DELAY = 20;
  localparam int MAXR      = 3;

  typedef logic [$bits(instr_t)-1:0] word_t;
  typedef struct {
    logic [ID_W-1:0] id;
    logic            err;
    logic            oerr;
    int              cyc;
  } done_t;
  typedef struct {
    cmd_t cmd;
    int   drop_word;
    int   never_word;
    bit   exp_err;
    bit   exp_oerr;
  } vec_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cmd_valid;
  logic            cmd_ready;
  cmd_t            cmd;
  logic            done_valid;
  logic [ID_W-1:0] done_id;
  logic            done_err;
  logic            err;

  proc_issuer_if pif ();

  proc_issuer #(.DEPTH(4), .MAX_RETRY(MAXR), .TIMEOUT(1024)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd        (cmd),
    .proc         (pif),
    .o_done_valid (done_valid),
    .o_done_id    (done_id),
    .o_done_err   (done_err),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Proc model: busy from start until the finish ack; acks each setup word on
  // the following cycle unless told to drop it once or to never ack it.
  int   drop_word  = -1;
  int   never_word = -1;
  logic hold_busy  = 1'b0;
  logic m_busy, m_ack, m_finish, m_dropped;
  int   m_words, m_fin_cnt;

  assign pif.busy   = m_busy | hold_busy;
  assign pif.ack    = m_ack;
  assign pif.finish = m_finish;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_ack <= 1'b0; m_finish <= 1'b0; m_dropped <= 1'b0;
      m_words <= 0; m_fin_cnt <= 0;
    end else begin
      m_ack <= 1'b0;
      if (pif.en) begin
        m_busy <= 1'b1; m_words <= 0; m_dropped <= 1'b0;
      end else if (pif.valid && m_finish) begin
        m_finish <= 1'b0; m_busy <= 1'b0;
      end else if (pif.valid && m_busy && m_words < 4) begin
        if (m_words == drop_word && !m_dropped) begin
          m_dropped <= 1'b1;
        end else if (m_words != never_word) begin
          m_ack   <= 1'b1;
          m_words <= m_words + 1;
          if (m_words == 3) m_fin_cnt <= FIN_DELAY;
        end
      end
      if (m_fin_cnt != 0) begin
        m_fin_cnt <= m_fin_cnt - 1;
        if (m_fin_cnt == 1) m_finish <= 1'b1;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  word_t pulse_q[$];
  int    pulse_cyc[$];
  done_t done_q[$];
  int    en_n = 0, en_cyc = 0, viol = 0;
  logic  prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (pif.valid) begin
        pulse_q.push_back(word_t'(pif.instr));
        pulse_cyc.push_back(cyc);
      end
      if (pif.en) begin
        en_n++;
        en_cyc = cyc;
      end
      if (pif.en && pif.valid) viol++;
      if (pif.valid && prev_valid) viol++;
      prev_valid = pif.valid;
      if (done_valid) begin
        done_t d;
        d.id = done_id; d.err = done_err; d.oerr = err; d.cyc = cyc;
        done_q.push_back(d);
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic cmd_t mk(input int id, input int op, input int cnt,
                              input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] d);
    cmd_t c;
    c.id = ID_W'(id); c.op = 2'(op); c.count = CNT_W'(cnt);
    c.src0 = s0; c.src1 = s1; c.dst = d;
    return c;
  endfunction

  function automatic word_t exp_word(input cmd_t c, input int w);
    case (w)
      0:       return {2'b01, c.src0};
      1:       return {2'b01, c.src1};
      2:       return {2'b10, 14'd0, c.op, c.count};
      default: return {2'b11, c.dst};
    endcase
  endfunction

  task automatic push(input cmd_t c, output int pcyc);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("push ready", cmd_ready, 1);
    pcyc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
  endtask

  task automatic clear_mon();
    pulse_q.delete(); pulse_cyc.delete(); done_q.delete();
    en_n = 0; viol = 0;
  endtask

  vec_t  vecs[5];
  cmd_t  fill[5];
  word_t exp_q[$];

  initial begin
    int pcyc, nsetup, bad, k;
    string s;

    vecs[0] = '{mk(3, 0, 8, 32'h100, 32'h200, 32'h300), -1, -1, 1'b0, 1'b0};
    vecs[1] = '{mk(5, 1, 16, 32'hA0, 32'hB0, 32'hC0), 2, -1, 1'b0, 1'b0};
    vecs[2] = '{mk(6, 2, 1, 32'h1111, 32'h2222, 32'h3333), 0, -1, 1'b0, 1'b0};
    vecs[3] = '{mk(7, 0, 0, 32'h10, 32'h20, 32'h30), -1, -1, 1'b1, 1'b0};
    vecs[4] = '{mk(9, 0, 4, 32'h100, 32'h200, 32'h300), -1, 1, 1'b1, 1'b1};

    rstn = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    #1 rstn = 1'b0;
    #2;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset en", pif.en, 0);
    check("reset valid", pif.valid, 0);
    check("reset instr", pif.instr, 0);
    check("reset done_valid", done_valid, 0);
    check("reset err", err, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      drop_word  = vecs[i].drop_word;
      never_word = vecs[i].never_word;
      clear_mon();
      push(vecs[i].cmd, pcyc);
      wait_done(1, 400);

      exp_q.delete();
      nsetup = 0;
      if (vecs[i].cmd.count != 0) begin
        for (int w = 0; w < 4; w++) begin
          k = (w == vecs[i].drop_word) ? 2 : 1;
          if (w == vecs[i].never_word) k = 1 + MAXR;
          repeat (k) exp_q.push_back(exp_word(vecs[i].cmd, w));
          nsetup += k;
          if (w == vecs[i].never_word) break;
        end
        if (vecs[i].never_word < 0) exp_q.push_back('0);
      end

      s = $sformatf("v%0d", i);
      check({s, " en count"}, en_n, (vecs[i].cmd.count != 0) ? 1 : 0);
      if (vecs[i].cmd.count != 0) check({s, " en latency"}, en_cyc, pcyc + 1);
      else if (done_q.size() > 0) check({s, " done latency"}, done_q[0].cyc <= pcyc + 2, 1);
      check({s, " pulse count"}, pulse_q.size(), exp_q.size());
      for (int p = 0; p < exp_q.size() && p < pulse_q.size(); p++)
        check($sformatf("%s pulse %0d", s, p), pulse_q[p], exp_q[p]);
      bad = 0;
      for (int p = 1; p < nsetup && p < pulse_cyc.size(); p++)
        if (pulse_cyc[p] - pulse_cyc[p-1] != 2) bad++;
      check({s, " pulse spacing"}, bad, 0);
      check({s, " en/valid protocol"}, viol, 0);
      check({s, " done count"}, done_q.size(), 1);
      if (done_q.size() > 0) begin
        check({s, " done id"}, done_q[0].id, vecs[i].cmd.id);
        check({s, " done err"}, done_q[0].err, vecs[i].exp_err);
        check({s, " o_err"}, done_q[0].oerr, vecs[i].exp_oerr);
      end
    end

    // Reset while waiting for finish, with a second command still queued.
    do_reset();
    drop_word = -1;
    never_word = -1;
    clear_mon();
    push(mk(2, 0, 4, 32'h40, 32'h50, 32'h60), pcyc);
    push(mk(4, 1, 4, 32'h70, 32'h80, 32'h90), pcyc);
    k = 0;
    while (pulse_q.size() < 4 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("rst setup words sent", pulse_q.size(), 4);
    repeat (4) @(posedge clk);
    done_q.delete();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst en", pif.en, 0);
    check("rst valid", pif.valid, 0);
    check("rst instr", pif.instr, 0);
    check("rst done_valid", done_valid, 0);
    check("rst done_id", done_id, 0);
    check("rst done_err", done_err, 0);
    check("rst err", err, 0);
    check("rst cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    en_n = 0;
    repeat (30) @(posedge clk);
    check("rst fifo empty (no start)", en_n, 0);
    check("rst no done pulse", done_q.size(), 0);
    push(mk(11, 2, 2, 32'hAA, 32'hBB, 32'hCC), pcyc);
    wait_done(1, 400);
    check("post-rst done count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check("post-rst done id", done_q[0].id, 11);
      check("post-rst done err", done_q[0].err, 0);
    end

    // Fill the FIFO while the proc reports busy, then drain in order.
    for (int i = 0; i < 5; i++)
      fill[i] = mk(i, 0, 4, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'h3000 + 32'(i));
    clear_mon();
    hold_busy = 1'b1;
    @(negedge clk);
    cmd = fill[0];
    cmd_valid = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("fill ready after push %0d", i), cmd_ready, (i < 4) ? 1 : 0);
      cmd = fill[i];
    end
    hold_busy = 1'b0;
    k = 0;
    while (!cmd_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("fill 5th accepted", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(5, 1500);
    check("fill done count", done_q.size(), 5);
    for (int i = 0; i < 5 && i < done_q.size(); i++) begin
      check($sformatf("fill done %0d id", i), done_q[i].id, i);
      check($sformatf("fill done %0d err", i), done_q[i].err, 0);
    end
    check("fill en/valid protocol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
